// File: rtl/frb_trigger_ctrl.sv
// frb_trigger_ctrl: sequencing and threshold-detection controller for the
// moving mean/variance statistics datapath of the FRB detection chain.
//   IDLE -> FLUSH (stat_rst held) -> WARMUP (window fill) -> ARMED
//   ARMED -> TRIGGERED (one-cycle trig) -> HOLDOFF -> ARMED
// Detection: (sample - mean)^2 > variance << K_SHIFT, three pipeline stages.
// Optional build macro FRB_TRIG_BIPOLAR_EN: negative excursions also trigger.
module frb_trigger_ctrl #(
    parameter int DIN_WIDTH    = 25,
    parameter int WINDOW_LEN   = 128,
    parameter int FLUSH_CYCLES = 8,
    parameter int HOLDOFF_LEN  = 64,
    parameter int K_SHIFT      = 4,
    parameter int TS_WIDTH     = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     enable,
    input  logic [DIN_WIDTH-1:0]     samp,
    input  logic [DIN_WIDTH-1:0]     stat_avg,
    input  logic [2*DIN_WIDTH:0]     stat_var,
    input  logic                     stat_valid,
    output logic                     stat_rst,
    output logic                     armed,
    output logic                     trig,
    output logic [TS_WIDTH-1:0]      trig_ts,
    output logic [DIN_WIDTH:0]       trig_dev,
    output logic [2:0]               state_dbg
);

    localparam int VAR_W   = 2*DIN_WIDTH + 1;
    localparam int DEV_W   = DIN_WIDTH + 1;
    localparam int DSQ_W   = 2*DIN_WIDTH + 2;
    localparam int THR_W   = VAR_W + K_SHIFT;
    localparam int CMP_W   = (DSQ_W > THR_W) ? DSQ_W : THR_W;
    localparam int CNT_MAX = (FLUSH_CYCLES > WINDOW_LEN)
                           ? ((FLUSH_CYCLES > HOLDOFF_LEN) ? FLUSH_CYCLES : HOLDOFF_LEN)
                           : ((WINDOW_LEN > HOLDOFF_LEN) ? WINDOW_LEN : HOLDOFF_LEN);
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_FLUSH     = 3'd1,
        S_WARMUP    = 3'd2,
        S_ARMED     = 3'd3,
        S_TRIGGERED = 3'd4,
        S_HOLDOFF   = 3'd5
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [TS_WIDTH-1:0]  ts_q, ts_d;
    logic [TS_WIDTH-1:0]  trig_ts_q, trig_ts_d;
    logic [DEV_W-1:0]     trig_dev_q, trig_dev_d;

    // Pipeline stage 1: deviation, clamped variance, timestamp tag
    logic                 v1_q, v1_d;
    logic [DEV_W-1:0]     dev1_q, dev1_d;
    logic [VAR_W-1:0]     varc1_q, varc1_d;
    logic [TS_WIDTH-1:0]  tag1_q, tag1_d;
    // Pipeline stage 2: squared deviation and scaled threshold
    logic                 v2_q, v2_d;
    logic [DEV_W-1:0]     dev2_q, dev2_d;
    logic [DSQ_W-1:0]     dsq2_q, dsq2_d;
    logic [THR_W-1:0]     thr2_q, thr2_d;
    logic [TS_WIDTH-1:0]  tag2_q, tag2_d;
    // Pipeline stage 3: comparison result
    logic                 v3_q, v3_d;
    logic                 hit3_q, hit3_d;
    logic [DEV_W-1:0]     dev3_q, dev3_d;
    logic [TS_WIDTH-1:0]  tag3_q, tag3_d;

    logic                 pipe_flush;
    logic signed [DSQ_W-1:0] dev_ext;
    logic [CMP_W-1:0]     dsq_cmp, thr_cmp;

    assign pipe_flush = ~enable | (state_q == S_IDLE);

    // Detector datapath: stage data loads only on a valid input, valid bits shift every clock
    always_comb begin
        v1_d    = stat_valid & ~pipe_flush;
        v2_d    = v1_q & ~pipe_flush;
        v3_d    = v2_q & ~pipe_flush;
        dev1_d  = dev1_q;
        varc1_d = varc1_q;
        tag1_d  = tag1_q;
        dev2_d  = dev2_q;
        dsq2_d  = dsq2_q;
        thr2_d  = thr2_q;
        tag2_d  = tag2_q;
        hit3_d  = hit3_q;
        dev3_d  = dev3_q;
        tag3_d  = tag3_q;
        dev_ext = DSQ_W'($signed(dev1_q));
        dsq_cmp = CMP_W'(dsq2_q);
        thr_cmp = CMP_W'(thr2_q);

        if (stat_valid) begin
            dev1_d  = {samp[DIN_WIDTH-1], samp} - {stat_avg[DIN_WIDTH-1], stat_avg};
            varc1_d = stat_var[VAR_W-1] ? '0 : stat_var;
            tag1_d  = ts_q;
        end
        if (v1_q) begin
            dsq2_d = dev_ext * dev_ext;
            thr2_d = THR_W'(varc1_q) << K_SHIFT;
            dev2_d = dev1_q;
            tag2_d = tag1_q;
        end
        if (v2_q) begin
`ifdef FRB_TRIG_BIPOLAR_EN
            hit3_d = (dsq_cmp > thr_cmp);
`else
            hit3_d = ~dev2_q[DEV_W-1] & (|dev2_q) & (dsq_cmp > thr_cmp);
`endif
            dev3_d = dev2_q;
            tag3_d = tag2_q;
        end
    end

    // Pipeline registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1_q    <= 1'b0;
            v2_q    <= 1'b0;
            v3_q    <= 1'b0;
            dev1_q  <= '0;
            varc1_q <= '0;
            tag1_q  <= '0;
            dev2_q  <= '0;
            dsq2_q  <= '0;
            thr2_q  <= '0;
            tag2_q  <= '0;
            hit3_q  <= 1'b0;
            dev3_q  <= '0;
            tag3_q  <= '0;
        end else begin
            v1_q    <= v1_d;
            v2_q    <= v2_d;
            v3_q    <= v3_d;
            dev1_q  <= dev1_d;
            varc1_q <= varc1_d;
            tag1_q  <= tag1_d;
            dev2_q  <= dev2_d;
            dsq2_q  <= dsq2_d;
            thr2_q  <= thr2_d;
            tag2_q  <= tag2_d;
            hit3_q  <= hit3_d;
            dev3_q  <= dev3_d;
            tag3_q  <= tag3_d;
        end
    end

    // Next-state, sample counters, timestamp and trigger capture
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        ts_d       = ts_q;
        trig_ts_d  = trig_ts_q;
        trig_dev_d = trig_dev_q;

        if (stat_valid && (state_q != S_IDLE) && (state_q != S_FLUSH))
            ts_d = ts_q + TS_WIDTH'(1);

        if (!enable) begin
            state_d = S_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_d = S_FLUSH;
                    cnt_d   = '0;
                    ts_d    = '0;
                end
                S_FLUSH: begin
                    if (FLUSH_CYCLES <= 1 || cnt_q == CNT_W'(FLUSH_CYCLES - 1)) begin
                        state_d = S_WARMUP;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                S_WARMUP: begin
                    if (stat_valid) begin
                        if (WINDOW_LEN <= 1 || cnt_q == CNT_W'(WINDOW_LEN - 1)) begin
                            state_d = S_ARMED;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end
                S_ARMED: begin
                    if (v3_q && hit3_q) begin
                        state_d    = S_TRIGGERED;
                        cnt_d      = '0;
                        trig_ts_d  = tag3_q;
                        trig_dev_d = dev3_q;
                    end
                end
                S_TRIGGERED: begin
                    // a valid in this cycle already counts toward the holdoff
                    if (HOLDOFF_LEN == 0 || (HOLDOFF_LEN == 1 && stat_valid)) begin
                        state_d = S_ARMED;
                        cnt_d   = '0;
                    end else begin
                        state_d = S_HOLDOFF;
                        cnt_d   = stat_valid ? CNT_W'(1) : '0;
                    end
                end
                S_HOLDOFF: begin
                    if (stat_valid) begin
                        if (cnt_q == CNT_W'(HOLDOFF_LEN - 1)) begin
                            state_d = S_ARMED;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Control state registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            ts_q       <= '0;
            trig_ts_q  <= '0;
            trig_dev_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ts_q       <= ts_d;
            trig_ts_q  <= trig_ts_d;
            trig_dev_q <= trig_dev_d;
        end
    end

    assign stat_rst  = (state_q == S_IDLE) || (state_q == S_FLUSH);
    assign armed     = (state_q == S_ARMED);
    assign trig      = (state_q == S_TRIGGERED);
    assign trig_ts   = trig_ts_q;
    assign trig_dev  = trig_dev_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_frb_trigger_ctrl.sv
// Directed bench for frb_trigger_ctrl. Samples use 24 fractional bits, so
// DIN_WIDTH is widened to 28 to hold +4.0 / -5.0; variance 1.0 is 1<<48.
module tb_frb_trigger_ctrl;

    localparam int DW = 28;
    localparam int VW = 2*DW + 1;
    localparam int TW = 32;

    localparam logic [DW-1:0]        FOUR  = 28'd67108864;          // 4.0
    localparam logic [DW-1:0]        FOURP = 28'd67108865;          // 4.0 + 1 LSB
    localparam logic signed [DW-1:0] NEG5  = -28'sd83886080;        // -5.0
    localparam logic [VW-1:0]        VAR1  = 57'd1 << 48;           // 1.0
    localparam logic [VW-1:0]        VARM3 = -57'sd3;               // -3 LSB

    logic           clk = 1'b0;
    logic           rst;
    logic           enable;
    logic [DW-1:0]  samp;
    logic [DW-1:0]  stat_avg;
    logic [VW-1:0]  stat_var;
    logic           stat_valid;
    logic           stat_rst;
    logic           armed;
    logic           trig;
    logic [TW-1:0]  trig_ts;
    logic [DW:0]    trig_dev;
    logic [2:0]     state_dbg;

    int total = 0;
    int bad = 0;
    int trig_seen = 0;
    int cyc = 0;
    int exp_idx = 0;

    frb_trigger_ctrl #(
        .DIN_WIDTH    (DW),
        .WINDOW_LEN   (128),
        .FLUSH_CYCLES (8),
        .HOLDOFF_LEN  (64),
        .K_SHIFT      (4),
        .TS_WIDTH     (TW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .samp       (samp),
        .stat_avg   (stat_avg),
        .stat_var   (stat_var),
        .stat_valid (stat_valid),
        .stat_rst   (stat_rst),
        .armed      (armed),
        .trig       (trig),
        .trig_ts    (trig_ts),
        .trig_dev   (trig_dev),
        .state_dbg  (state_dbg)
    );

    always #5 clk = ~clk;

    initial begin
        #200us;
        $display("FAIL watchdog: simulation time limit reached");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "watchdog");
    end

    // One clock: inputs applied at a negedge, outputs observed at the next negedge
    task automatic drive(input logic v, input logic [DW-1:0] s, input logic [VW-1:0] vr);
        stat_valid = v;
        samp       = s;
        stat_avg   = '0;
        stat_var   = vr;
        @(negedge clk);
        cyc++;
        if (v) exp_idx++;
        if (trig) trig_seen++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, '0, VAR1);
    endtask

    task automatic recover();
        for (int i = 0; i < 200 && state_dbg != 3'd3; i++) drive(1'b1, '0, VAR1);
        total++;
        if (state_dbg !== 3'd3) begin bad++; $display("FAIL recover_armed: got %0d want 3", state_dbg); end
    endtask

    task automatic test_reset();
        rst = 1'b1; enable = 1'b0; stat_valid = 1'b0; samp = '0; stat_avg = '0; stat_var = '0;
        repeat (3) @(negedge clk);
        total++; if (state_dbg !== 3'd0) begin bad++; $display("FAIL rst_state: got %0d want 0", state_dbg); end
        total++; if (stat_rst !== 1'b1) begin bad++; $display("FAIL rst_stat_rst: got %0b want 1", stat_rst); end
        total++; if (armed !== 1'b0) begin bad++; $display("FAIL rst_armed: got %0b want 0", armed); end
        total++; if (trig !== 1'b0) begin bad++; $display("FAIL rst_trig: got %0b want 0", trig); end
        total++; if (trig_ts !== '0) begin bad++; $display("FAIL rst_trig_ts: got %0d want 0", trig_ts); end
        total++; if (trig_dev !== '0) begin bad++; $display("FAIL rst_trig_dev: got %0d want 0", trig_dev); end
        rst = 1'b0;
        idle(2);
        total++; if (state_dbg !== 3'd0) begin bad++; $display("FAIL idle_hold: got %0d want 0", state_dbg); end
    endtask

    task automatic test_start_up();
        int n;
        enable = 1'b1;
        idle(1);
        total++; if (state_dbg !== 3'd1 || stat_rst !== 1'b1) begin
            bad++; $display("FAIL flush_entry: state %0d stat_rst %0b want 1/1", state_dbg, stat_rst);
        end
        n = 0;
        for (int i = 0; i < 40 && state_dbg == 3'd1; i++) begin
            if (stat_rst === 1'b1) n++;
            idle(1);
        end
        total++; if (n != 8) begin bad++; $display("FAIL flush_len: got %0d want 8", n); end
        total++; if (state_dbg !== 3'd2 || stat_rst !== 1'b0) begin
            bad++; $display("FAIL warmup_entry: state %0d stat_rst %0b want 2/0", state_dbg, stat_rst);
        end
        exp_idx = 0;
        for (int i = 0; i < 127; i++) drive(1'b1, '0, VAR1);
        idle(3);
        total++; if (armed !== 1'b0) begin bad++; $display("FAIL armed_early: got %0b want 0", armed); end
        drive(1'b1, '0, VAR1);
        total++; if (armed !== 1'b1 || state_dbg !== 3'd3) begin
            bad++; $display("FAIL armed_128: armed %0b state %0d want 1/3", armed, state_dbg);
        end
    endtask

    task automatic test_threshold();
        int t0;
        int idx;
        t0 = trig_seen;
        drive(1'b1, FOUR, VAR1);
        idle(6);
        total++; if (trig_seen != t0) begin bad++; $display("FAIL thr_equal: got %0d trigs want 0", trig_seen - t0); end
        idx = exp_idx;
        drive(1'b1, FOURP, VAR1);
        idle(2);
        total++; if (trig !== 1'b0) begin bad++; $display("FAIL thr_early: got %0b want 0", trig); end
        idle(1);
        total++; if (trig !== 1'b1) begin bad++; $display("FAIL thr_fire: got %0b want 1", trig); end
        total++; if (trig_ts !== TW'(idx)) begin bad++; $display("FAIL thr_ts: got %0d want %0d", trig_ts, idx); end
        total++; if (trig_dev !== {1'b0, FOURP}) begin bad++; $display("FAIL thr_dev: got %0d want %0d", trig_dev, FOURP); end
        idle(1);
        total++; if (trig !== 1'b0 || state_dbg !== 3'd5) begin
            bad++; $display("FAIL thr_pulse: trig %0b state %0d want 0/5", trig, state_dbg);
        end
        for (int i = 0; i < 63; i++) drive(1'b1, '0, VAR1);
        total++; if (state_dbg !== 3'd5) begin bad++; $display("FAIL holdoff_63: got %0d want 5", state_dbg); end
        drive(1'b1, '0, VAR1);
        total++; if (state_dbg !== 3'd3) begin bad++; $display("FAIL holdoff_64: got %0d want 3", state_dbg); end
    endtask

    task automatic test_negative();
        int t0;
        int idx;
        logic signed [DW:0] exp_dev;
        exp_dev = NEG5;
        t0 = trig_seen;
        idx = exp_idx;
        drive(1'b1, NEG5, VAR1);
        idle(6);
`ifdef FRB_TRIG_BIPOLAR_EN
        total++; if (trig_seen != t0 + 1) begin bad++; $display("FAIL neg_fire: got %0d trigs want 1", trig_seen - t0); end
        total++; if (trig_dev !== exp_dev) begin bad++; $display("FAIL neg_dev: got %0h want %0h", trig_dev, exp_dev); end
        total++; if (trig_ts !== TW'(idx)) begin bad++; $display("FAIL neg_ts: got %0d want %0d", trig_ts, idx); end
        recover();
`else
        total++; if (trig_seen != t0) begin bad++; $display("FAIL neg_nofire: got %0d trigs want 0 (dev %0h idx %0d)", trig_seen - t0, exp_dev, idx); end
        total++; if (state_dbg !== 3'd3) begin bad++; $display("FAIL neg_state: got %0d want 3", state_dbg); end
`endif
    endtask

    task automatic test_neg_var();
        int idx;
        idx = exp_idx;
        drive(1'b1, 28'd1, VARM3);
        idle(3);
        total++; if (trig !== 1'b1) begin bad++; $display("FAIL negvar_fire: got %0b want 1", trig); end
        total++; if (trig_dev !== 29'd1) begin bad++; $display("FAIL negvar_dev: got %0d want 1", trig_dev); end
        total++; if (trig_ts !== TW'(idx)) begin bad++; $display("FAIL negvar_ts: got %0d want %0d", trig_ts, idx); end
        idle(1);
        recover();
    endtask

    task automatic test_back_to_back();
        int t0;
        int idx;
        int first;
        int second;
        int early;
        t0 = trig_seen; idx = exp_idx; first = -1; second = -1; early = 0;
        for (int k = 1; k <= 75; k++) begin
            drive(1'b1, FOURP, VAR1);
            if (trig) begin
                if (first < 0) first = k;
                else if (second < 0) second = k;
            end
            if (k == 60) early = trig_seen - t0;
        end
        total++; if (first != 4) begin bad++; $display("FAIL b2b_first: got %0d want 4", first); end
        total++; if (early != 1) begin bad++; $display("FAIL b2b_single: got %0d trigs want 1", early); end
        total++; if (second != 69) begin bad++; $display("FAIL b2b_second: got %0d want 69", second); end
        total++; if (trig_ts !== TW'(idx + 65)) begin bad++; $display("FAIL b2b_ts: got %0d want %0d", trig_ts, idx + 65); end
        total++; if (trig_seen - t0 != 2) begin bad++; $display("FAIL b2b_count: got %0d want 2", trig_seen - t0); end
        recover();
    endtask

    task automatic test_abort();
        int t0;
        logic [TW-1:0] saved_ts;
        saved_ts = trig_ts;
        t0 = trig_seen;
        drive(1'b1, FOURP, VAR1);
        idle(1);
        enable = 1'b0;
        idle(8);
        total++; if (trig_seen != t0) begin bad++; $display("FAIL abort_nofire: got %0d trigs want 0", trig_seen - t0); end
        total++; if (state_dbg !== 3'd0 || stat_rst !== 1'b1) begin
            bad++; $display("FAIL abort_idle: state %0d stat_rst %0b want 0/1", state_dbg, stat_rst);
        end
        total++; if (trig_ts !== saved_ts) begin bad++; $display("FAIL abort_ts_hold: got %0d want %0d", trig_ts, saved_ts); end
        test_start_up();
        drive(1'b1, FOURP, VAR1);
        idle(3);
        total++; if (trig !== 1'b1 || trig_ts !== TW'(128)) begin
            bad++; $display("FAIL rerun_ts: trig %0b ts %0d want 1/128", trig, trig_ts);
        end
    endtask

    initial begin
        test_reset();
        test_start_up();
        test_threshold();
        test_negative();
        test_neg_var();
        test_back_to_back();
        test_abort();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
